// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } fetch_state_e;

    localparam int          INST_BYTES       = 4;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

endpackage

// File: rtl/fetch_redirect_mux.sv
// Priority select of the fetch redirect: trap/CSR over EXE mispredict over ID jump.
module fetch_redirect_mux #(
    parameter int ADDR_W = 64
) (
    input  logic              trap_valid,
    input  logic [ADDR_W-1:0] trap_pc,
    input  logic              exe_redirect,
    input  logic [ADDR_W-1:0] exe_pc,
    input  logic              id_redirect,
    input  logic [ADDR_W-1:0] id_pc,
    output logic              redir,
    output logic [ADDR_W-1:0] target
);

    always_comb begin
        redir  = trap_valid | exe_redirect | id_redirect;
        target = id_pc;
        if (trap_valid) begin
            target = trap_pc;
        end else if (exe_redirect) begin
            target = exe_pc;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, one outstanding imem request, stale-drop and ID-stall buffer.
// Define FETCH_PERF_CNT_EN to add saturating perf counters and their output ports.
module if_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT[ADDR_W-1:0]
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trap_valid,
    input  logic [ADDR_W-1:0] trap_pc,
    input  logic              exe_redirect,
    input  logic [ADDR_W-1:0] exe_pc,
    input  logic              id_redirect,
    input  logic [ADDR_W-1:0] id_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [INST_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [63:0]       perf_redirects,
    output logic [63:0]       perf_drops,
    output logic [63:0]       perf_stall_cycles
`endif
);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc;
    logic [INST_W-1:0] buf_inst;
    logic              redir;
    logic [ADDR_W-1:0] target;

    fetch_redirect_mux #(.ADDR_W(ADDR_W)) u_redirect_mux (
        .trap_valid   (trap_valid),
        .trap_pc      (trap_pc),
        .exe_redirect (exe_redirect),
        .exe_pc       (exe_pc),
        .id_redirect  (id_redirect),
        .id_pc        (id_pc),
        .redir        (redir),
        .target       (target)
    );

    assign pc_inc = pc_q + ADDR_W'(INST_BYTES);

    // Outputs are decoded from state so a response can be handed to ID in its arrival cycle.
    always_comb begin
        imem_req_valid = 1'b0;
        imem_req_addr  = '0;
        if_valid       = 1'b0;
        if_inst        = '0;
        if_pc          = '0;
        case (state)
            S_REQ: begin
                imem_req_valid = ~redir;
                imem_req_addr  = pc_q;
            end
            S_WAIT: begin
                if (imem_rsp_valid && !redir) begin
                    if_valid = 1'b1;
                    if_inst  = imem_rsp_data;
                    if_pc    = pc_q;
                end
            end
            S_HOLD: begin
                if (!redir) begin
                    if_valid = 1'b1;
                    if_inst  = buf_inst;
                    if_pc    = pc_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc_q  <= RESET_PC;
        end else begin
            if (redir) begin
                pc_q <= target;
            end else if (if_valid && if_ready) begin
                pc_q <= pc_inc;
            end
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (!redir && imem_req_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state <= (redir || if_ready) ? S_REQ : S_HOLD;
                    end else if (redir) begin
                        state <= S_DROP;
                    end
                end
                S_HOLD: begin
                    if (redir || if_ready) state <= S_REQ;
                end
                S_DROP: begin
                    if (imem_rsp_valid) state <= S_REQ;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Data-only register: its contents matter only while state is S_HOLD.
    always_ff @(posedge clk) begin
        if (state == S_WAIT && imem_rsp_valid && !redir && !if_ready) begin
            buf_inst <= imem_rsp_data;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [63:0] sat_inc(input logic [63:0] v);
        return (&v) ? v : v + 64'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_redirects    <= '0;
            perf_drops        <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (redir) perf_redirects <= sat_inc(perf_redirects);
            if (imem_rsp_valid && ((state == S_WAIT && redir) || state == S_DROP)) begin
                perf_drops <= sat_inc(perf_drops);
            end
            if (state == S_HOLD && !if_ready) perf_stall_cycles <= sat_inc(perf_stall_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a latency-configurable memory model and a scoreboard monitor.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        trap_valid, exe_redirect, id_redirect;
    logic [63:0] trap_pc, exe_pc, id_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid, if_ready;
    logic [31:0] if_inst;
    logic [63:0] if_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [63:0] perf_redirects, perf_drops, perf_stall_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 2;

    logic [63:0] exp_req[$];
    logic [63:0] exp_pc[$];
    logic [31:0] exp_inst[$];

    if_fetch_ctrl #(.ADDR_W(64), .INST_W(32), .RESET_PC(64'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .exe_redirect   (exe_redirect),
        .exe_pc         (exe_pc),
        .id_redirect    (id_redirect),
        .id_pc          (id_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .if_pc          (if_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_redirects    (perf_redirects),
        .perf_drops        (perf_drops),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Memory model: response comes lat cycles after the acceptance cycle; data = addr + 0x1000_0000.
    initial begin
        logic        pend;
        logic [63:0] pend_addr;
        int          cnt;
        pend = 1'b0;
        pend_addr = '0;
        cnt = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && imem_req_valid && imem_req_ready) begin
                pend      = 1'b1;
                pend_addr = imem_req_addr;
                cnt       = lat;
            end
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = pend_addr[31:0] + 32'h1000_0000;
                    pend = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && imem_req_valid && imem_req_ready) begin
                if (exp_req.size() == 0) chk("unexpected_req", imem_req_addr, 64'hDEAD_BEEF);
                else chk("req_addr", imem_req_addr, exp_req.pop_front());
            end
            if (rst_n && if_valid && if_ready) begin
                if (exp_pc.size() == 0) begin
                    chk("unexpected_inst", if_pc, 64'hDEAD_BEEF);
                end else begin
                    chk("if_pc", if_pc, exp_pc.pop_front());
                    chk("if_inst", {32'h0, if_inst}, {32'h0, exp_inst.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        trap_valid = 1'b0; exe_redirect = 1'b0; id_redirect = 1'b0;
        trap_pc = '0; exe_pc = '0; id_pc = '0;
        imem_req_ready = 1'b1;
        if_ready = 1'b1;

        repeat (3) tick();
        mid();
        chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        chk("rst_req_addr", imem_req_addr, 64'h0);
        chk("rst_if_valid", {63'h0, if_valid}, 64'h0);
        chk("rst_if_pc", if_pc, 64'h0);
        chk("rst_if_inst", {32'h0, if_inst}, 64'h0);

        // Sequential fetch at 0x0, 0x4, 0x8 (and 0xC issued afterwards).
        exp_req.push_back(64'h0); exp_req.push_back(64'h4);
        exp_req.push_back(64'h8); exp_req.push_back(64'hC);
        exp_pc.push_back(64'h0); exp_inst.push_back(32'h1000_0000);
        exp_pc.push_back(64'h4); exp_inst.push_back(32'h1000_0004);
        exp_pc.push_back(64'h8); exp_inst.push_back(32'h1000_0008);
        tick(); rst_n = 1'b1; mid();
        chk("idle_no_req", {63'h0, imem_req_valid}, 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick(); mid();
            chk("seq_req_valid", {63'h0, imem_req_valid}, 64'h1);
            tick(); mid();
            chk("seq_wait_no_valid", {63'h0, if_valid}, 64'h0);
            tick(); mid();
            chk("seq_deliver", {63'h0, if_valid}, 64'h1);
        end
        tick(); mid();
        chk("next_req_after_rsp", {63'h0, imem_req_valid}, 64'h1);

        // EXE redirect in S_WAIT; response one cycle later must be dropped.
        exp_req.push_back(64'h100);
        exp_pc.push_back(64'h100); exp_inst.push_back(32'h1000_0100);
        tick(); exe_redirect = 1'b1; exe_pc = 64'h100; mid();
        chk("redir_no_valid", {63'h0, if_valid}, 64'h0);
        tick(); exe_redirect = 1'b0; mid();
        chk("drop_no_valid", {63'h0, if_valid}, 64'h0);
        tick(); mid();
        chk("redir_req_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("redir_req_addr", imem_req_addr, 64'h100);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_drops", perf_drops, 64'd1);
        chk("perf_redirects", perf_redirects, 64'd1);
`endif
        tick(); mid();
        tick(); mid();
        chk("redir_target_deliver", {63'h0, if_valid}, 64'h1);

        // All three redirect sources at once: trap wins.
        exp_req.push_back(64'h8000_0000);
        exp_pc.push_back(64'h8000_0000); exp_inst.push_back(32'h9000_0000);
        tick();
        trap_valid = 1'b1; trap_pc = 64'h8000_0000;
        exe_redirect = 1'b1; exe_pc = 64'h200;
        id_redirect = 1'b1; id_pc = 64'h300;
        mid();
        chk("prio_no_req", {63'h0, imem_req_valid}, 64'h0);
        tick(); trap_valid = 1'b0; exe_redirect = 1'b0; id_redirect = 1'b0; mid();
        chk("prio_req_addr", imem_req_addr, 64'h8000_0000);

        // ID stall for 3 cycles while the response arrives.
        tick(); if_ready = 1'b0; mid();
        tick(); mid();
        chk("stall_valid", {63'h0, if_valid}, 64'h1);
        chk("stall_inst", {32'h0, if_inst}, 64'h9000_0000);
        for (int i = 0; i < 2; i++) begin
            tick(); mid();
            chk("hold_valid", {63'h0, if_valid}, 64'h1);
            chk("hold_inst", {32'h0, if_inst}, 64'h9000_0000);
            chk("hold_pc", if_pc, 64'h8000_0000);
            chk("hold_no_req", {63'h0, imem_req_valid}, 64'h0);
        end
        tick(); if_ready = 1'b1; mid();
        tick(); imem_req_ready = 1'b0; mid();
        chk("post_hold_req_addr", imem_req_addr, 64'h8000_0004);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall", perf_stall_cycles, 64'd2);
`endif

        // Memory not ready, then ID redirect to 0x40.
        for (int i = 0; i < 3; i++) begin
            tick(); mid();
            chk("notready_valid", {63'h0, imem_req_valid}, 64'h1);
            chk("notready_addr", imem_req_addr, 64'h8000_0004);
        end
        exp_req.push_back(64'h40);
        tick(); id_redirect = 1'b1; id_pc = 64'h40; mid();
        chk("idredir_no_req", {63'h0, imem_req_valid}, 64'h0);
        tick(); id_redirect = 1'b0; mid();
        chk("idredir_req_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("idredir_req_addr", imem_req_addr, 64'h40);
        tick(); mid();
        chk("idredir_addr_stable", imem_req_addr, 64'h40);
        tick(); imem_req_ready = 1'b1; lat = 4; mid();
        tick(); imem_req_ready = 1'b0; mid();
        chk("wait_no_req", {63'h0, imem_req_valid}, 64'h0);

        // Asynchronous reset while in S_WAIT; the late response must be ignored.
        tick(); rst_n = 1'b0; #1;
        chk("arst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        chk("arst_if_valid", {63'h0, if_valid}, 64'h0);
        chk("arst_req_addr", imem_req_addr, 64'h0);
        chk("arst_if_pc", if_pc, 64'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("arst_perf_redirects", perf_redirects, 64'd0);
`endif
        mid();
        lat = 2;
        exp_req.push_back(64'h0);
        exp_pc.push_back(64'h0); exp_inst.push_back(32'h1000_0000);
        tick(); rst_n = 1'b1; mid();
        chk("arst_idle_no_req", {63'h0, imem_req_valid}, 64'h0);
        tick(); mid();
        chk("late_rsp_ignored", {63'h0, if_valid}, 64'h0);
        chk("arst_pc_reset", imem_req_addr, 64'h0);
        tick(); imem_req_ready = 1'b1; mid();
        tick(); imem_req_ready = 1'b0; mid();
        tick(); mid();
        chk("post_reset_deliver", {63'h0, if_valid}, 64'h1);

        repeat (3) begin tick(); mid(); end
        chk("req_queue_empty", 64'(exp_req.size()), 64'h0);
        chk("inst_queue_empty", 64'(exp_pc.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
